// File: rtl/fir_cfg_pkg.sv
// Shared definitions for the FIR configuration master: command opcodes,
// controller states and the FIR accelerator's AXI-Lite register map.
package fir_cfg_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_AR,
    ST_RD_R,
    ST_POLL_GAP,
    ST_RSP
  } state_t;

  localparam logic [11:0] ADDR_AP_CTRL  = 12'h000;
  localparam logic [11:0] ADDR_DATA_LEN = 12'h010;
  localparam logic [11:0] ADDR_TAP_BASE = 12'h020;

  localparam int unsigned AP_START_BIT = 0;
  localparam int unsigned AP_DONE_BIT  = 1;
  localparam int unsigned AP_IDLE_BIT  = 2;

  function automatic logic [11:0] tap_addr(input int unsigned idx);
    return ADDR_TAP_BASE + 12'(idx * 4);
  endfunction

endpackage

// File: rtl/fir_cfg_master.sv
// AXI-Lite initiator that executes write / read / poll commands against the
// FIR configuration port and returns one response per command.
module fir_cfg_master
  import fir_cfg_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pPOLL_MAX   = 16,
  parameter int pPOLL_GAP   = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [pADDR_WIDTH-1:0] cmd_addr,
  input  logic [pDATA_WIDTH-1:0] cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [pDATA_WIDTH-1:0] rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata
);

  localparam int CW = $clog2(pPOLL_MAX + 1);
  localparam int GW = (pPOLL_GAP > 0) ? $clog2(pPOLL_GAP + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(pPOLL_MAX - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((pPOLL_GAP > 0) ? pPOLL_GAP - 1 : 0);

  state_t                 state, state_nxt;
  logic [1:0]             op;
  logic [pDATA_WIDTH-1:0] mask;
  logic [CW-1:0]          poll_cnt;
  logic [GW-1:0]          gap_cnt;
  logic                   poll_hit, poll_last;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign poll_hit  = |(rdata & mask);
  assign poll_last = (poll_cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE:         state_nxt = ST_WR;
            OP_READ, OP_POLL: state_nxt = ST_RD_AR;
            default:          state_nxt = ST_RSP;
          endcase
        end
      end
      ST_WR: begin
        // A channel already dropped its valid has completed its handshake.
        if ((!awvalid || awready) && (!wvalid || wready)) state_nxt = ST_RSP;
      end
      ST_RD_AR: if (arready) state_nxt = ST_RD_R;
      ST_RD_R: begin
        if (rvalid) begin
          if (op != OP_POLL || poll_hit || poll_last) state_nxt = ST_RSP;
          else if (pPOLL_GAP == 0)                      state_nxt = ST_RD_AR;
          else                                          state_nxt = ST_POLL_GAP;
        end
      end
      ST_POLL_GAP: if (gap_cnt == '0) state_nxt = ST_RD_AR;
      ST_RSP:      if (rsp_ready) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Read-side valids and rsp_valid are registered copies of the next state,
  // so they rise on the edge that enters their state and fall on the exit.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      op        <= '0;
      mask      <= '0;
      poll_cnt  <= '0;
      gap_cnt   <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      wdata     <= '0;
      araddr    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      arvalid   <= (state_nxt == ST_RD_AR);
      rready    <= (state_nxt == ST_RD_R);
      rsp_valid <= (state_nxt == ST_RSP);
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op       <= cmd_op;
            mask     <= cmd_data;
            poll_cnt <= '0;
            case (cmd_op)
              OP_WRITE: begin
                awaddr  <= cmd_addr;
                wdata   <= cmd_data;
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
              end
              OP_READ, OP_POLL: araddr <= cmd_addr;
              default: begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
              end
            endcase
          end
        end
        ST_WR: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (state_nxt == ST_RSP) begin
            rsp_data <= wdata;
            rsp_err  <= 1'b0;
          end
        end
        ST_RD_R: begin
          if (rvalid) begin
            poll_cnt <= poll_cnt + CW'(1);
            rsp_data <= rdata;
            rsp_err  <= (op == OP_POLL) && !poll_hit && poll_last;
            gap_cnt  <= GAP_LOAD;
          end
        end
        ST_POLL_GAP: gap_cnt <= gap_cnt - GW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_cfg_master.sv
// Randomized self-checking bench for fir_cfg_master: a delay-configurable
// AXI-Lite responder plus a command-level reference model.
module tb_fir_cfg_master;
  import fir_cfg_pkg::*;

  localparam int PMAX = 16;
  localparam int PGAP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err, busy;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;

  fir_cfg_master #(
    .pADDR_WIDTH(12), .pDATA_WIDTH(32), .pPOLL_MAX(PMAX), .pPOLL_GAP(PGAP)
  ) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rready(rready), .rdata(rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_w = 0, w_w = 0, ar_w = 0, r_w = 0;
  logic [31:0] read_q[$];
  int n_aw, n_w, n_ar, ar_cyc[$];
  logic [11:0] exp_addr, got_awaddr;
  logic [31:0] got_wdata;
  int addr_bad = 0, proto_bad = 0, aw_first = 0, any_valid = 0;
  bit p_aw, p_w, p_ar;
  logic [11:0] p_awaddr, p_araddr;
  logic [31:0] p_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // AXI-Lite responder: each ready/rvalid rises a configurable number of
  // cycles after the matching valid/rready; read data comes from read_q.
  initial begin
    {awready, wready, arready, rvalid} = '0;
    rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {awready, wready, arready, rvalid} = '0;
        {aw_w, w_w, ar_w, r_w} = '0;
      end else begin
        awready = awvalid && (aw_w >= aw_dly);  aw_w = awvalid ? aw_w + 1 : 0;
        wready  = wvalid  && (w_w  >= w_dly);   w_w  = wvalid  ? w_w  + 1 : 0;
        arready = arvalid && (ar_w >= ar_dly);  ar_w = arvalid ? ar_w + 1 : 0;
        rvalid  = rready && (r_w >= r_dly) && (read_q.size() != 0);
        rdata   = (read_q.size() != 0) ? read_q[0] : 32'h0;
        r_w     = rready ? r_w + 1 : 0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (awvalid && awready) begin n_aw++; got_awaddr = awaddr; end
      if (wvalid && wready)   begin n_w++;  got_wdata  = wdata;  end
      if (arvalid && arready) begin
        n_ar++;
        ar_cyc.push_back(cyc);
        if (araddr != exp_addr) addr_bad++;
      end
      if (rvalid && rready) void'(read_q.pop_front());
      if (p_aw && !(awvalid && awaddr == p_awaddr)) proto_bad++;
      if (p_w  && !(wvalid  && wdata  == p_wdata))  proto_bad++;
      if (p_ar && !(arvalid && araddr == p_araddr)) proto_bad++;
      p_aw = awvalid && !awready;  p_awaddr = awaddr;
      p_w  = wvalid  && !wready;   p_wdata  = wdata;
      p_ar = arvalid && !arready;  p_araddr = araddr;
      if (busy && !awvalid && wvalid) aw_first++;
      if (awvalid || wvalid || arvalid || rready) any_valid++;
    end else begin
      {p_aw, p_w, p_ar} = '0;
    end
    cyc++;
  end

  // Expected response from the command semantics and the scripted read values.
  task automatic model(input logic [1:0] op, input logic [31:0] data, input logic [31:0] vals[$],
                       output logic [31:0] ed, output logic ee, output int nr);
    ed = '0; ee = 1'b0; nr = 0;
    case (op)
      OP_WRITE: ed = data;
      OP_READ:  begin ed = vals[0]; nr = 1; end
      OP_POLL: begin
        ee = 1'b1;
        for (int i = 0; i < PMAX && i < vals.size(); i++) begin
          nr = i + 1;
          ed = vals[i];
          if ((vals[i] & data) != 0) begin ee = 1'b0; break; end
        end
      end
      default: ee = 1'b1;
    endcase
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data,
                         input int hold, output logic [31:0] rd, output logic re,
                         output int lat, output bit ok, output int stab);
    int t, c0;
    exp_addr = addr;
    n_aw = 0; n_w = 0; n_ar = 0; ar_cyc.delete();
    addr_bad = 0; aw_first = 0; any_valid = 0;
    stab = 0; lat = -1; ok = 1'b0; rd = '0; re = 1'b0;
    @(negedge clk);
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) return;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    @(posedge clk); #1;
    c0 = cyc;
    cmd_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!rsp_valid && t < 2000);
    if (!rsp_valid) return;
    ok = 1'b1;
    lat = cyc - c0 + 1;
    rd = rsp_data; re = rsp_err;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== rd || rsp_err !== re || cmd_ready) stab++;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_and_check(input string tag, input logic [1:0] op, input logic [11:0] addr,
                              input logic [31:0] data, input logic [31:0] vals[$],
                              input int hold, output int lat);
    logic [31:0] rd, ed;
    logic re, ee;
    int nr, stab;
    bit ok;
    read_q = vals;
    run_cmd(op, addr, data, hold, rd, re, lat, ok, stab);
    model(op, data, vals, ed, ee, nr);
    check({tag, ".done"}, ok, 1);
    check({tag, ".data"}, rd, ed);
    check({tag, ".err"}, re, ee);
    check({tag, ".reads"}, n_ar, nr);
    check({tag, ".araddr"}, addr_bad, 0);
    check({tag, ".hold"}, stab, 0);
    if (op == OP_WRITE) begin
      check({tag, ".aw_n"}, n_aw, 1);
      check({tag, ".w_n"}, n_w, 1);
      check({tag, ".awaddr"}, got_awaddr, addr);
      check({tag, ".wdata"}, got_wdata, data);
    end else begin
      check({tag, ".no_wr"}, n_aw + n_w, 0);
    end
  endtask

  initial begin
    logic [31:0] vals[$];
    logic [31:0] m, v;
    logic [1:0]  op;
    logic [11:0] a;
    int lat, bad, sel;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ctl", {cmd_ready, rsp_valid, rsp_err, busy, awvalid, wvalid, arvalid, rready}, 8'b1000_0000);
    check("rst.addr", {awaddr, araddr}, 24'h0);
    check("rst.data", {wdata, rsp_data}, 64'h0);
    @(negedge clk); rst_n = 1'b1;

    // Zero-wait write latency and return to idle.
    vals = {};
    do_and_check("wr0", OP_WRITE, ADDR_DATA_LEN, 32'h0000_0258, vals, 0, lat);
    check("wr0.lat", lat, 2);
    check("wr0.idle", cmd_ready, 1);

    // awready two cycles ahead of wready.
    aw_dly = 0; w_dly = 2;
    do_and_check("wr1", OP_WRITE, ADDR_TAP_BASE, 32'hFFFF_FFF6, vals, 0, lat);
    check("wr1.aw_first", aw_first != 0, 1);
    check("wr1.lat", lat, 4);
    w_dly = 0;

    vals = '{32'h0000_0123};
    do_and_check("rd0", OP_READ, ADDR_AP_CTRL, 32'h0, vals, 0, lat);
    check("rd0.lat", lat, 3);

    ar_dly = 3;
    vals = '{32'h0000_0258};
    do_and_check("rd1", OP_READ, ADDR_DATA_LEN, 32'h0, vals, 0, lat);
    check("rd1.lat", lat, 6);
    ar_dly = 0;

    vals = '{32'h4, 32'h4, 32'h4, 32'h6};
    do_and_check("poll0", OP_POLL, ADDR_AP_CTRL, 32'h2, vals, 0, lat);
    check("poll0.lat", lat, 21);
    bad = 0;
    for (int i = 1; i < ar_cyc.size(); i++) if (ar_cyc[i] - ar_cyc[i-1] != 2 + PGAP) bad++;
    check("poll0.period", bad, 0);

    vals = {};
    for (int i = 0; i < PMAX - 1; i++) vals.push_back($urandom & ~32'h2);
    vals.push_back(32'h0000_0005);
    do_and_check("poll_to", OP_POLL, ADDR_AP_CTRL, 32'h2, vals, 0, lat);
    check("poll_to.lat", lat, 3 + (2 + PGAP) * (PMAX - 1));

    vals = {};
    for (int i = 0; i < PMAX - 1; i++) vals.push_back(32'hFFFF_FFFF);
    vals.push_back(32'h7FFF_FFFF);
    do_and_check("poll_m0", OP_POLL, ADDR_AP_CTRL, 32'h0, vals, 0, lat);

    vals = {};
    do_and_check("resv", 2'b11, ADDR_AP_CTRL, 32'hDEAD_BEEF, vals, 5, lat);
    check("resv.lat", lat, 1);
    check("resv.no_axi", any_valid, 0);

    // Reset asserted while the read data phase is waiting.
    r_dly = 20;
    read_q = '{32'h1234_5678};
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = ADDR_DATA_LEN; cmd_data = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !rready; i++) @(negedge clk);
    check("rst_mid.in_rd_r", rready, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.drop", {arvalid, rready, rsp_valid, awvalid, wvalid, busy}, 6'b0);
    check("rst_mid.ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r_dly = 0;
    read_q.delete();
    vals = {};
    do_and_check("rst_mid.wr", OP_WRITE, tap_addr(3), 32'hA5A5_0003, vals, 0, lat);
    check("rst_mid.lat", lat, 2);

    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 9);
      op = (sel < 4) ? OP_WRITE : (sel < 6) ? OP_READ : (sel < 9) ? OP_POLL : 2'b11;
      case ($urandom_range(0, 2))
        0:       a = ADDR_AP_CTRL;
        1:       a = ADDR_DATA_LEN;
        default: a = tap_addr($urandom_range(0, 10));
      endcase
      m = '0;
      repeat ($urandom_range(0, 2)) m = m | (32'h1 << $urandom_range(0, 31));
      if (op != OP_POLL) m = $urandom;
      vals = {};
      for (int i = 0; i < PMAX; i++) begin
        v = $urandom;
        if ($urandom_range(0, 4) != 0) v = v & ~m;
        vals.push_back(v);
      end
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      do_and_check("rnd", op, a, m, vals, $urandom_range(0, 3), lat);
    end

    check("proto.stable", proto_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
